// File: rtl/cell_heap.sv
// Cons-cell heap: 48-bit cells {header, car, cdr}, single-ported storage.
// A read walks IDLE->ADDR->RWAIT->RDONE. A bump-pointer allocation
// walks IDLE->WRITE. Cell 0 is NIL and is never written.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   read_enable     one-cycle read request, honoured only in IDLE
//   addr_in         cell address, captured in ADDR (one edge later)
//   header_out      bit 15 GC mark, bits 14:0 type tag
//   car_out         car field
//   cdr_out         cdr field
//   done            one-cycle pulse, read data valid
//   rd_error        valid with done, address was out of range
//   alloc_valid     allocation request
//   alloc_ready     request accepted when alloc_valid is also high
//   alloc_header    header for the new cell
//   alloc_car       car for the new cell
//   alloc_cdr       cdr for the new cell
//   alloc_addr      address of the cell just written
//   alloc_done      one-cycle pulse, alloc_addr valid
//   oom             sticky heap-exhausted flag
//   free_ptr        next address to allocate
module cell_heap #(
    parameter int    DEPTH        = 1024,
    parameter int    READ_LATENCY = 2,
    parameter int    FIRST_FREE   = 64,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_enable,
    input  logic [15:0] addr_in,
    output logic [15:0] header_out,
    output logic [15:0] car_out,
    output logic [15:0] cdr_out,
    output logic        done,
    output logic        rd_error,
    input  logic        alloc_valid,
    output logic        alloc_ready,
    input  logic [15:0] alloc_header,
    input  logic [15:0] alloc_car,
    input  logic [15:0] alloc_cdr,
    output logic [15:0] alloc_addr,
    output logic        alloc_done,
    output logic        oom,
    output logic [15:0] free_ptr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RWAIT,
        RDONE,
        WRITE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [47:0] mem [DEPTH];

    logic [15:0] addr_q;
    logic [3:0]  lat_cnt;
    logic [47:0] wdata_q;
    logic [15:0] rd_addr;
    logic        rd_ok;
    logic [47:0] rd_word;
    logic        fp_last;

    // With READ_LATENCY==1 the address is used on the same edge it is
    // captured, so look through the capture register while in ADDR.
    assign rd_addr = (state == ADDR) ? addr_in : addr_q;
    assign rd_ok   = ({16'd0, rd_addr} < 32'(DEPTH));
    assign rd_word = rd_ok ? mem[rd_addr[AW-1:0]] : '0;
    assign fp_last = (({16'd0, free_ptr} + 32'd1) == 32'(DEPTH));

    always_comb begin
        state_nx    = state;
        alloc_ready = 1'b0;
        unique case (state)
            IDLE: begin
                alloc_ready = !read_enable && !oom;
                if (read_enable) begin
                    state_nx = ADDR;
                end else if (alloc_valid && alloc_ready) begin
                    state_nx = WRITE;
                end
            end
            ADDR: begin
                if (READ_LATENCY <= 1) begin
                    state_nx = RDONE;
                end else begin
                    state_nx = RWAIT;
                end
            end
            RWAIT: begin
                // Counter reaches zero on this edge.
                if (lat_cnt <= 4'd1) begin
                    state_nx = RDONE;
                end
            end
            RDONE:   state_nx = IDLE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            lat_cnt    <= '0;
            wdata_q    <= '0;
            header_out <= '0;
            car_out    <= '0;
            cdr_out    <= '0;
            done       <= 1'b0;
            rd_error   <= 1'b0;
            alloc_addr <= '0;
            alloc_done <= 1'b0;
            oom        <= 1'b0;
            free_ptr   <= 16'(FIRST_FREE);
        end else begin
            done       <= 1'b0;
            alloc_done <= 1'b0;

            // Latch the payload at the accept edge; the requester
            // may change it afterwards.
            if (state == IDLE && state_nx == WRITE) begin
                wdata_q <= {alloc_header, alloc_car, alloc_cdr};
            end

            if (state == ADDR) begin
                addr_q  <= addr_in;
                lat_cnt <= LAT_M1;
            end

            if (state == RWAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            if (state != RDONE && state_nx == RDONE) begin
                header_out <= rd_word[47:32];
                car_out    <= rd_word[31:16];
                cdr_out    <= rd_word[15:0];
                rd_error   <= !rd_ok;
                done       <= 1'b1;
            end

            if (state == WRITE) begin
                alloc_addr <= free_ptr;
                alloc_done <= 1'b1;
                free_ptr   <= free_ptr + 16'd1;
                if (fp_last) begin
                    oom <= 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; a write is abandoned if rst drops
    // the FSM out of WRITE before the edge.
    always_ff @(posedge clk) begin
        if (state == WRITE) begin
            mem[free_ptr[AW-1:0]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_cell_heap.sv
// Directed bench for cell_heap: a default-size heap and a 66-cell heap
// share all inputs; sel picks which one's outputs are compared.
module tb_cell_heap;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_enable;
    logic [15:0] addr_in;
    logic        alloc_valid;
    logic [15:0] alloc_header;
    logic [15:0] alloc_car;
    logic [15:0] alloc_cdr;

    logic [15:0] header_out, car_out, cdr_out, alloc_addr, free_ptr;
    logic        done, rd_error, alloc_ready, alloc_done, oom;

    logic [15:0] s_header_out, s_car_out, s_cdr_out;
    logic [15:0] s_alloc_addr, s_free_ptr;
    logic        s_done, s_rd_error, s_alloc_ready, s_alloc_done, s_oom;

    logic sel = 1'b0;

    logic [15:0] m_hdr, m_car, m_cdr, m_aaddr, m_fptr;
    logic        m_done, m_err, m_ready, m_adone, m_oom;

    assign m_hdr   = sel ? s_header_out  : header_out;
    assign m_car   = sel ? s_car_out     : car_out;
    assign m_cdr   = sel ? s_cdr_out     : cdr_out;
    assign m_aaddr = sel ? s_alloc_addr  : alloc_addr;
    assign m_fptr  = sel ? s_free_ptr    : free_ptr;
    assign m_done  = sel ? s_done        : done;
    assign m_err   = sel ? s_rd_error    : rd_error;
    assign m_ready = sel ? s_alloc_ready : alloc_ready;
    assign m_adone = sel ? s_alloc_done  : alloc_done;
    assign m_oom   = sel ? s_oom         : oom;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cell_heap dut (
        .clk(clk), .rst(rst),
        .read_enable(read_enable), .addr_in(addr_in),
        .header_out(header_out), .car_out(car_out),
        .cdr_out(cdr_out), .done(done), .rd_error(rd_error),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_header(alloc_header), .alloc_car(alloc_car),
        .alloc_cdr(alloc_cdr), .alloc_addr(alloc_addr),
        .alloc_done(alloc_done), .oom(oom), .free_ptr(free_ptr)
    );

    cell_heap #(.DEPTH(66)) dut_s (
        .clk(clk), .rst(rst),
        .read_enable(read_enable), .addr_in(addr_in),
        .header_out(s_header_out), .car_out(s_car_out),
        .cdr_out(s_cdr_out), .done(s_done), .rd_error(s_rd_error),
        .alloc_valid(alloc_valid), .alloc_ready(s_alloc_ready),
        .alloc_header(alloc_header), .alloc_car(alloc_car),
        .alloc_cdr(alloc_cdr), .alloc_addr(s_alloc_addr),
        .alloc_done(s_alloc_done), .oom(s_oom), .free_ptr(s_free_ptr)
    );

    typedef struct {
        logic        sel;
        logic [15:0] addr;
        int          hold;
        logic [15:0] h;
        logic [15:0] c;
        logic [15:0] d;
        logic        err;
    } rvec_t;

    task automatic chk(input string nm, input logic [47:0] act,
                       input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // read_enable in cycle 0 (held for 'hold' cycles); addr_in is the
    // target only in cycle 1, decoy cells 3/7 otherwise.
    task automatic do_read(input string nm, input logic [15:0] a,
                           input int hold, input logic [15:0] eh,
                           input logic [15:0] ec, input logic [15:0] ed,
                           input logic ee);
        int first = -1;
        int np = 0;
        logic [15:0] h = '0, c = '0, d = '0;
        logic e = 1'b0;
        @(posedge clk); #1;
        read_enable = 1'b1;
        addr_in = 16'h0003;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_done) begin
                np++;
                if (first < 0) begin
                    first = i;
                    h = m_hdr; c = m_car; d = m_cdr; e = m_err;
                end
            end
            @(posedge clk); #1;
            read_enable = (i + 1 < hold);
            addr_in = (i == 0) ? a : 16'h0007;
        end
        chk({nm, " done_cycle"}, 48'(first), 48'd3);
        chk({nm, " done_pulses"}, 48'(np), 48'd1);
        chk({nm, " data"}, {h, c, d}, {eh, ec, ed});
        chk({nm, " rd_error"}, 48'(e), 48'(ee));
        @(negedge clk);
        chk({nm, " data_hold"}, {m_hdr, m_car, m_cdr}, {eh, ec, ed});
    endtask

    task automatic do_alloc(input string nm, input logic [15:0] h,
                            input logic [15:0] c, input logic [15:0] d,
                            input int eacc, input int edone,
                            input logic [15:0] eaddr,
                            input logic [15:0] efp, input logic eoom);
        int acc = -1;
        int dc = -1;
        logic [15:0] aa = '0;
        logic [15:0] fp = '0;
        @(posedge clk); #1;
        alloc_valid = 1'b1;
        alloc_header = h; alloc_car = c; alloc_cdr = d;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_adone && dc < 0) begin
                dc = i; aa = m_aaddr; fp = m_fptr;
            end
            if (acc < 0 && m_ready) acc = i;
            @(posedge clk); #1;
            if (acc >= 0) begin
                alloc_valid = 1'b0;
                alloc_header = 16'hFFFF;
                alloc_car = 16'hFFFF;
                alloc_cdr = 16'hFFFF;
            end
        end
        alloc_valid = 1'b0;
        @(negedge clk);
        chk({nm, " accept_cycle"}, 48'(acc), 48'(eacc));
        chk({nm, " done_cycle"}, 48'(dc), 48'(edone));
        chk({nm, " alloc_addr"}, 48'(aa), 48'(eaddr));
        if (dc >= 0) chk({nm, " free_ptr_at_done"}, 48'(fp), 48'(efp));
        chk({nm, " free_ptr"}, 48'(m_fptr), 48'(efp));
        chk({nm, " oom"}, 48'(m_oom), 48'(eoom));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    rvec_t rv [7];

    initial begin
        int rd, ry, ad, np;
        logic [15:0] aa;

        rv[0] = '{1'b0, 16'd5,    1, 16'h0001, 16'h002A, 16'h0000, 1'b0};
        rv[1] = '{1'b0, 16'h0400, 1, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        rv[2] = '{1'b0, 16'd9,    1, 16'h8123, 16'h0040, 16'h0041, 1'b0};
        rv[3] = '{1'b0, 16'hFFFF, 1, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        rv[4] = '{1'b0, 16'd1023, 1, 16'h7FFF, 16'hABCD, 16'h1234, 1'b0};
        rv[5] = '{1'b0, 16'd0,    1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        rv[6] = '{1'b0, 16'd5,    4, 16'h0001, 16'h002A, 16'h0000, 1'b0};

        rst = 1'b1;
        read_enable = 1'b0;
        addr_in = '0;
        alloc_valid = 1'b0;
        alloc_header = '0;
        alloc_car = '0;
        alloc_cdr = '0;

        dut.mem[0]      <= 48'h0000_0000_0000;
        dut.mem[3]      <= 48'h0BAD_0BAD_0BAD;
        dut.mem[5]      <= 48'h0001_002A_0000;
        dut.mem[7]      <= 48'h0EEE_0EEE_0EEE;
        dut.mem[9]      <= 48'h8123_0040_0041;
        dut.mem[1023]   <= 48'h7FFF_ABCD_1234;
        dut_s.mem[0]    <= 48'h0000_0000_0000;
        dut_s.mem[3]    <= 48'h0BAD_0BAD_0BAD;
        dut_s.mem[5]    <= 48'h0001_002A_0000;
        dut_s.mem[7]    <= 48'h0EEE_0EEE_0EEE;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset outputs", {header_out, car_out, cdr_out}, 48'd0);
        chk("reset done", 48'(done), 48'd0);
        chk("reset rd_error", 48'(rd_error), 48'd0);
        chk("reset alloc_done", 48'(alloc_done), 48'd0);
        chk("reset alloc_addr", 48'(alloc_addr), 48'd0);
        chk("reset oom", 48'(oom), 48'd0);
        chk("reset free_ptr", 48'(free_ptr), 48'd64);
        chk("reset alloc_ready", 48'(alloc_ready), 48'd1);

        for (int i = 0; i < 7; i++) begin
            sel = rv[i].sel;
            do_read($sformatf("read[%0d]", i), rv[i].addr, rv[i].hold,
                    rv[i].h, rv[i].c, rv[i].d, rv[i].err);
        end
        sel = 1'b0;

        // Allocate then read back.
        do_alloc("alloc1", 16'h0002, 16'h0005, 16'h0000,
                 0, 2, 16'd64, 16'd65, 1'b0);
        do_read("readback64", 16'd64, 1,
                16'h0002, 16'h0005, 16'h0000, 1'b0);

        // Read and allocation requested together: read wins.
        do_reset();
        rd = -1; ry = -1; ad = -1; aa = '0;
        @(posedge clk); #1;
        read_enable = 1'b1;
        addr_in = 16'h0003;
        alloc_valid = 1'b1;
        alloc_header = 16'h0004;
        alloc_car = 16'h0044;
        alloc_cdr = 16'h0444;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done && rd < 0) rd = i;
            if (alloc_ready && ry < 0) ry = i;
            if (alloc_done && ad < 0) begin
                ad = i; aa = alloc_addr;
            end
            @(posedge clk); #1;
            read_enable = 1'b0;
            addr_in = (i == 0) ? 16'd5 : 16'h0007;
            if (ry >= 0) alloc_valid = 1'b0;
        end
        alloc_valid = 1'b0;
        chk("simul read_done_cycle", 48'(rd), 48'd3);
        chk("simul first_ready_cycle", 48'(ry), 48'd4);
        chk("simul alloc_done_cycle", 48'(ad), 48'd6);
        chk("simul alloc_addr", 48'(aa), 48'd64);
        chk("simul read_data", {header_out, car_out, cdr_out},
            48'h0001_002A_0000);
        do_read("simul readback64", 16'd64, 1,
                16'h0004, 16'h0044, 16'h0444, 1'b0);

        // 66-cell heap runs out after two allocations.
        do_reset();
        sel = 1'b1;
        do_alloc("small a", 16'h0003, 16'h0011, 16'h0022,
                 0, 2, 16'd64, 16'd65, 1'b0);
        do_alloc("small b", 16'h0007, 16'h0041, 16'h0000,
                 0, 2, 16'd65, 16'd66, 1'b1);
        do_alloc("small c", 16'h0009, 16'h0099, 16'h0999,
                 -1, -1, 16'd0, 16'd66, 1'b1);
        chk("small ready_after_oom", 48'(m_ready), 48'd0);
        do_read("small read65", 16'd65, 1,
                16'h0007, 16'h0041, 16'h0000, 1'b0);
        do_read("small read66", 16'd66, 1,
                16'h0000, 16'h0000, 16'h0000, 1'b1);
        sel = 1'b0;

        // Reset in the middle of a read.
        do_reset();
        do_alloc("pre_rst alloc", 16'h0002, 16'h0005, 16'h0000,
                 0, 2, 16'd64, 16'd65, 1'b0);
        np = 0;
        @(posedge clk); #1;
        read_enable = 1'b1;
        addr_in = 16'h0003;
        @(posedge clk); #1;
        read_enable = 1'b0;
        addr_in = 16'd5;
        @(posedge clk); #1;
        addr_in = 16'h0007;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) np++;
            @(posedge clk); #1;
            if (i == 2) rst = 1'b0;
        end
        @(negedge clk);
        chk("midrst no_done", 48'(np), 48'd0);
        chk("midrst free_ptr", 48'(free_ptr), 48'd64);
        chk("midrst idle_ready", 48'(alloc_ready), 48'd1);
        chk("midrst outputs", {header_out, car_out, cdr_out}, 48'd0);
        do_read("midrst read5", 16'd5, 1,
                16'h0001, 16'h002A, 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
